// File: rtl/jk_cmd_seq.sv
// ============================================================================
// Module   : jk_cmd_seq
// Purpose  : Command sequencer for a JK flip-flop stage. Commands
//            (hold/clear/set/toggle plus a drive length) arrive over a
//            valid/ready handshake and wait in a small FIFO. Each command
//            drives the flip-flop j/k inputs for max(len,1) cycles. A shadow
//            q (o_q_model) follows the flip-flop without a readback.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH  command FIFO entries (power of 2, >= 2)
//   LEN_W  width of the per-command drive length
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous reset, active-low
//   i_cmd_valid  in   command offered
//   o_cmd_ready  out  FIFO can accept (registered, = !full)
//   i_cmd_op     in   {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
//   i_cmd_len    in   drive cycles, 0 treated as 1
//   i_flush      in   (JK_CMD_FLUSH_EN only) empty FIFO and abort drive
//   o_j, o_k     out  flip-flop j/k (registered)
//   o_busy       out  driving, or FIFO non-empty
//   o_done       out  high on the final drive cycle of each command
//   o_q_model    out  expected flip-flop q after the current clock edge
// Build option
//   JK_CMD_FLUSH_EN  when defined, adds the i_flush input port
// ============================================================================
`default_nettype none

module jk_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [LEN_W-1:0] i_cmd_len,
`ifdef JK_CMD_FLUSH_EN
    input  logic             i_flush,
`endif
    output logic             o_j,
    output logic             o_k,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_q_model
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_EW = 2 + LEN_W;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_DRIVE = 1'b1;

    // FIFO storage and bookkeeping
    logic [c_EW-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_ready;

    // Sequencer state
    logic [0:0]       r_state;
    logic [LEN_W-1:0] r_remaining;
    logic [1:0]       r_jk;
    logic             r_q;

    logic             w_flush;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_last;
    logic [c_EW-1:0]  w_head;
    logic [LEN_W-1:0] w_head_len;
    logic [c_CW-1:0]  w_count_nxt;

`ifdef JK_CMD_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_empty    = (r_count == '0);
    assign w_last     = (r_state == c_DRIVE) && (r_remaining == LEN_W'(1));
    // Flush discards a same-cycle push outright.
    assign w_push     = i_cmd_valid && r_ready && !w_flush;
    // Pop only from entries stored at an earlier edge (no bypass path).
    assign w_pop      = !w_empty && ((r_state == c_IDLE) || w_last);
    assign w_head     = r_mem[r_rd_ptr];
    // A zero length still drives for one cycle.
    assign w_head_len = (w_head[LEN_W-1:0] == '0) ? LEN_W'(1) : w_head[LEN_W-1:0];

    assign w_count_nxt = r_count + c_CW'(w_push) - c_CW'(w_pop);

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_cmd_op, i_cmd_len};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ready     <= 1'b0;
            r_state     <= c_IDLE;
            r_remaining <= '0;
            r_jk        <= 2'b00;
            r_q         <= 1'b0;
        end else begin
            // Shadow q follows the JK table using the j/k of the cycle ending now.
            case (r_jk)
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase

            if (w_flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_ready     <= 1'b1;
                r_state     <= c_IDLE;
                r_remaining <= '0;
                r_jk        <= 2'b00;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_AW'(1);
                end
                r_count <= w_count_nxt;
                r_ready <= (w_count_nxt != c_CW'(DEPTH));

                case (r_state)
                    c_IDLE: begin
                        if (w_pop) begin
                            r_state     <= c_DRIVE;
                            r_jk        <= w_head[c_EW-1:LEN_W];
                            r_remaining <= w_head_len;
                        end else begin
                            r_jk <= 2'b00;
                        end
                    end
                    c_DRIVE: begin
                        if (w_last) begin
                            if (w_pop) begin
                                // Back-to-back: next command starts without a gap.
                                r_jk        <= w_head[c_EW-1:LEN_W];
                                r_remaining <= w_head_len;
                            end else begin
                                r_state <= c_IDLE;
                                r_jk    <= 2'b00;
                            end
                        end else begin
                            r_remaining <= r_remaining - LEN_W'(1);
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_jk    <= 2'b00;
                    end
                endcase
            end
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_j         = r_jk[1];
    assign o_k         = r_jk[0];
    assign o_busy      = (r_state == c_DRIVE) || !w_empty;
    assign o_done      = w_last;
    assign o_q_model   = r_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_cmd_seq.sv
// ============================================================================
// Module   : tb_jk_cmd_seq
// Purpose  : Self-checking bench for jk_cmd_seq: a vector table for the
//            single-command and back-to-back cases, hand sequences for full
//            FIFO, reset mid-drive and flush, then random traffic against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_cmd_seq;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic [1:0] op_in;
    logic [3:0] len_in;
    logic       flush_in;
    logic       ready_o, j_o, k_o, busy_o, done_o, q_o;

    jk_cmd_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cmd_valid (valid_in),
        .o_cmd_ready (ready_o),
        .i_cmd_op    (op_in),
        .i_cmd_len   (len_in),
`ifdef JK_CMD_FLUSH_EN
        .i_flush     (flush_in),
`endif
        .o_j         (j_o),
        .o_k         (k_o),
        .o_busy      (busy_o),
        .o_done      (done_o),
        .o_q_model   (q_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // pend holds accepted commands not yet started; the active command is
    // described by its code and how many drive cycles remain after this one.
    typedef struct packed { logic [1:0] op; logic [3:0] len; } cmd_t;
    cmd_t pend[$];
    bit       m_inrst;
    bit       m_drv;
    logic [1:0] m_jk;
    int       m_left;
    bit       m_q;
    bit       m_ready;

    task automatic model_reset();
        pend.delete();
        m_inrst = 1; m_drv = 0; m_jk = 2'b00; m_left = 0; m_q = 0; m_ready = 0;
    endtask

    task automatic model_edge(input bit v, input logic [1:0] op, input logic [3:0] len, input bit fl);
        bit   acc;
        cmd_t c;
        if (m_inrst) return;
        acc = v && m_ready && !fl;
        case (m_jk)
            2'b01: m_q = 0;
            2'b10: m_q = 1;
            2'b11: m_q = !m_q;
            default: ;
        endcase
        if (fl) begin
            pend.delete();
            m_drv = 0; m_jk = 2'b00; m_left = 0;
        end else begin
            if (!m_drv || m_left == 0) begin
                if (pend.size() > 0) begin
                    c = pend.pop_front();
                    m_drv  = 1;
                    m_jk   = c.op;
                    m_left = ((c.len == 0) ? 1 : int'(c.len)) - 1;
                end else begin
                    m_drv = 0; m_jk = 2'b00;
                end
            end else begin
                m_left--;
            end
            if (acc) pend.push_back('{op: op, len: len});
        end
        m_ready = (pend.size() != DEPTH);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ready"}, ready_o, m_ready);
        chk({tag, "_j"},     j_o,     m_jk[1]);
        chk({tag, "_k"},     k_o,     m_jk[0]);
        chk({tag, "_done"},  done_o,  m_drv && (m_left == 0));
        chk({tag, "_busy"},  busy_o,  m_drv || (pend.size() > 0));
        chk({tag, "_q"},     q_o,     m_q);
    endtask

    // Drive inputs (blocking) away from the edge, advance one edge, settle at negedge.
    task automatic tick(input bit v, input logic [1:0] op, input logic [3:0] len, input bit fl);
        valid_in = v; op_in = op; len_in = len; flush_in = fl;
        @(posedge clk);
        model_edge(v, op, len, fl);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, 1), 2'($urandom), 4'($urandom), 1'($urandom));
            chk("rst_j", j_o, 0);
            chk("rst_k", k_o, 0);
            chk("rst_q", q_o, 0);
            chk("rst_ready", ready_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
        end
        rst_n = 1'b1;
        m_inrst = 0;
        tick(0, 2'b00, 4'd0, 0);
        chk("rel_ready", ready_o, 1);
        check_model("rel");
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         pre_rst;
        bit         v;
        logic [1:0] op;
        logic [3:0] len;
        bit         e_rdy, e_j, e_k, e_done, e_busy, e_q;
    } vec_t;
    vec_t tbl[12];

    initial begin
        // single set, len 3
        tbl[0]  = '{1, 1, 2'b10, 4'd3, 1, 0, 0, 0, 1, 0};
        tbl[1]  = '{0, 0, 2'b00, 4'd0, 1, 1, 0, 0, 1, 0};
        tbl[2]  = '{0, 0, 2'b00, 4'd0, 1, 1, 0, 0, 1, 1};
        tbl[3]  = '{0, 0, 2'b00, 4'd0, 1, 1, 0, 1, 1, 1};
        tbl[4]  = '{0, 0, 2'b00, 4'd0, 1, 0, 0, 0, 0, 1};
        // back-to-back: toggle/1, toggle/2, clear/0
        tbl[5]  = '{1, 1, 2'b11, 4'd1, 1, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 1, 2'b11, 4'd2, 1, 1, 1, 1, 1, 0};
        tbl[7]  = '{0, 1, 2'b01, 4'd0, 1, 1, 1, 0, 1, 1};
        tbl[8]  = '{0, 0, 2'b00, 4'd0, 1, 1, 1, 1, 1, 0};
        tbl[9]  = '{0, 0, 2'b00, 4'd0, 1, 0, 1, 1, 1, 1};
        tbl[10] = '{0, 0, 2'b00, 4'd0, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 2'b00, 4'd0, 1, 0, 0, 0, 0, 0};

        rst_n = 1'b0; valid_in = 0; op_in = 0; len_in = 0; flush_in = 0;
        model_reset();

        // reset behaviour
        do_reset(3);

        // table vectors
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].pre_rst) do_reset(2);
            tick(tbl[i].v, tbl[i].op, tbl[i].len, 0);
            chk($sformatf("tbl%0d_ready", i), ready_o, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_j", i),     j_o,     tbl[i].e_j);
            chk($sformatf("tbl%0d_k", i),     k_o,     tbl[i].e_k);
            chk($sformatf("tbl%0d_done", i),  done_o,  tbl[i].e_done);
            chk($sformatf("tbl%0d_busy", i),  busy_o,  tbl[i].e_busy);
            chk($sformatf("tbl%0d_q", i),     q_o,     tbl[i].e_q);
        end

        // full FIFO: DEPTH+2 offers of long commands in consecutive cycles
        do_reset(2);
        begin
            logic [1:0] ops [6] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
            for (int i = 0; i < DEPTH + 2; i++) begin
                tick(1, ops[i], 4'd15, 0);
                check_model("full");
            end
        end
        chk("full_ready_low", ready_o, 0);
        for (int i = 0; i < 90; i++) begin
            tick(0, 2'b00, 4'd0, 0);
            check_model("drain");
        end
        chk("drain_idle", busy_o, 0);

        // reset in the 2nd drive cycle of a len-5 set, with commands queued
        do_reset(1);
        tick(1, 2'b10, 4'd5, 0);
        tick(1, 2'b11, 4'd3, 0);
        tick(1, 2'b01, 4'd2, 0);
        check_model("pre_abort");
        chk("pre_abort_j", j_o, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_j", j_o, 0);
        chk("abort_k", k_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_ready", ready_o, 0);
        @(negedge clk);
        do_reset(2);
        for (int i = 0; i < 12; i++) begin
            tick(0, 2'b00, 4'd0, 0);
            check_model("post_abort");
        end

`ifdef JK_CMD_FLUSH_EN
        // flush with 3 queued and a push in the same cycle
        do_reset(1);
        tick(1, 2'b10, 4'd15, 0);
        tick(1, 2'b11, 4'd15, 0);
        tick(1, 2'b01, 4'd15, 0);
        tick(1, 2'b11, 4'd15, 0);
        check_model("pre_flush");
        tick(1, 2'b10, 4'd4, 1);
        chk("flush_j", j_o, 0);
        chk("flush_k", k_o, 0);
        chk("flush_busy", busy_o, 0);
        chk("flush_done", done_o, 0);
        chk("flush_ready", ready_o, 1);
        for (int i = 0; i < 8; i++) begin
            tick(0, 2'b00, 4'd0, 0);
            check_model("post_flush");
        end
`endif

        // random traffic against the model
        do_reset(1);
        for (int i = 0; i < 1500; i++) begin
            bit         v;
            bit         fl;
            logic [3:0] ln;
            v  = ($urandom % 3) != 0;
            ln = (($urandom % 8) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            fl = 0;
`ifdef JK_CMD_FLUSH_EN
            fl = ($urandom % 40) == 0;
`endif
            if (($urandom % 300) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                tick(v, 2'($urandom), ln, fl);
                check_model("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
